// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM encoding and default widths for the ALU/memory sequencer
package alu_seq_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_MEM_W  = 16;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_NOT = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;
   typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_LAT, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/alu_mem_sequencer.sv
// alu_mem_sequencer: reads two operands from result memory, runs them through the ALU, writes the result back
module alu_mem_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int MEM_W  = DEF_MEM_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_opcode,
   input  logic [ADDR_W-1:0] cmd_src1,
   input  logic [ADDR_W-1:0] cmd_src2,
   input  logic [ADDR_W-1:0] cmd_dst,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [MEM_W-1:0]  mem_wdata,
   input  logic [MEM_W-1:0]  mem_rdata,
   output logic [2:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   input  logic [DATA_W-1:0] alu_result,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] done_result
);
   state_t state, state_nxt;
   logic [2:0] opc;
   logic [ADDR_W-1:0] src1, src2, dst;
   logic [DATA_W-1:0] op1, op2, res;
   logic accept;
   logic unused_rdata_hi;
   assign accept = cmd_valid && cmd_ready;
   assign unused_rdata_hi = ^mem_rdata[MEM_W-1:DATA_W];
   always_ff @(posedge clk)
      state <= !rst_n ? S_IDLE : state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = accept ? S_RD1 : S_IDLE;
         S_RD1:   state_nxt = S_RD2;
         S_RD2:   state_nxt = S_LAT;
         S_LAT:   state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_WB;
         default: state_nxt = S_IDLE;
      endcase
   end
   // Registered read: data for the address driven in one state arrives in the next
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         opc         <= '0;
         src1        <= '0;
         src2        <= '0;
         dst         <= '0;
         op1         <= '0;
         op2         <= '0;
         res         <= '0;
         done        <= 1'b0;
         done_result <= '0;
      end else begin
         if (accept) begin
            opc  <= cmd_opcode;
            src1 <= cmd_src1;
            src2 <= cmd_src2;
            dst  <= cmd_dst;
         end
         if (state == S_RD2) op1 <= mem_rdata[DATA_W-1:0];
         if (state == S_LAT) op2 <= mem_rdata[DATA_W-1:0];
         if (state == S_EXEC) res <= alu_result;
         if (state == S_WB) done_result <= res;
         done <= state == S_WB;
      end
   end
   always_comb begin
      cmd_ready  = state == S_IDLE;
      busy       = state != S_IDLE;
      mem_we     = state == S_WB;
      mem_addr   = state == S_RD1 ? src1 : state == S_RD2 ? src2 : state == S_WB ? dst : '0;
      mem_wdata  = state == S_WB ? {{(MEM_W-DATA_W){1'b0}}, res} : '0;
      alu_opcode = opc;
      alu_op1    = op1;
      alu_op2    = op2;
   end
endmodule

// File: tb/tb_alu_mem_sequencer.sv
// tb_alu_mem_sequencer: directed commands with a queue-based scoreboard checking write-back and done
module tb_alu_mem_sequencer;
   logic clk, rst_n, cmd_valid, cmd_ready, mem_we, busy, done;
   logic [2:0] cmd_opcode, alu_opcode;
   logic [3:0] cmd_src1, cmd_src2, cmd_dst, mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [7:0] alu_op1, alu_op2, alu_result, done_result;
   logic [15:0] mem [16];
   int cyc = 0;
   int n_cmp = 0;
   int n_fail = 0;
   typedef struct {logic [3:0] dst; logic [7:0] res; int acc;} exp_t;
   exp_t exp_q[$];

   alu_mem_sequencer dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
      .busy(busy), .done(done), .done_result(done_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   always_comb begin
      alu_result = 8'h00;
      case (alu_opcode)
         3'b000: alu_result = alu_op1 + alu_op2;
         3'b001: alu_result = alu_op1 - alu_op2;
         3'b010: alu_result = ~alu_op1;
         3'b011: alu_result = alu_op1 & alu_op2;
         3'b100: alu_result = alu_op1 | alu_op2;
         3'b101: alu_result = alu_op1 ^ alu_op2;
         3'b110: alu_result = alu_op1 << 1;
         default: alu_result = alu_op1 >> 1;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: write-back and done are checked against the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_we) begin
            if (exp_q.size() == 0) chk("spurious_write", 32'(mem_we), 32'd0);
            else begin
               chk("wb_addr", 32'(mem_addr), 32'(exp_q[0].dst));
               chk("wb_data", 32'(mem_wdata), {24'h0, exp_q[0].res});
               chk("wb_latency", 32'(cyc - exp_q[0].acc), 32'd5);
            end
         end
         if (done) begin
            if (exp_q.size() == 0) chk("spurious_done", 32'(done), 32'd0);
            else begin
               chk("done_result", 32'(done_result), {24'h0, exp_q[0].res});
               chk("done_latency", 32'(cyc - exp_q[0].acc), 32'd6);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d, input logic [7:0] r, input bit push, output int acc);
      int n;
      cmd_opcode = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 20) chk("accept_timeout", 32'(cmd_ready), 32'd1);
      acc = cyc;
      @(posedge clk); #1;
      if (push) exp_q.push_back('{d, r, acc});
   endtask

   task automatic wait_idle();
      int n;
      cmd_valid = 1'b0;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 40) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic run1(input logic [2:0] op, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic [7:0] r);
      int a;
      issue(op, s1, s2, d, r, 1'b1, a);
      wait_idle();
   endtask

   initial begin
      int a1, a2;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      mem[0] = 16'h0010; mem[1] = 16'h0020; mem[2] = 16'h0030;
      mem[5] = 16'h0081; mem[7] = 16'hFF05; mem[15] = 16'h1234;
      rst_n = 1'b0; cmd_valid = 1'b0;
      cmd_opcode = 3'b0; cmd_src1 = 4'h0; cmd_src2 = 4'h0; cmd_dst = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_done_result", 32'(done_result), 32'd0);
      chk("rst_mem_ctl", {11'h0, mem_addr, mem_we, mem_wdata}, 32'd0);
      chk("rst_alu", {13'h0, alu_opcode, alu_op1, alu_op2}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run1(3'b000, 4'd0, 4'd1, 4'd3, 8'h30);
      chk("done_cleared", 32'(done), 32'd0);
      chk("done_result_held", 32'(done_result), 32'h30);
      run1(3'b001, 4'd0, 4'd1, 4'd4, 8'hF0);
      run1(3'b001, 4'd3, 4'd2, 4'd6, 8'h00);
      run1(3'b000, 4'd7, 4'd0, 4'd8, 8'h15);
      run1(3'b110, 4'd5, 4'd2, 4'd9, 8'h02);
      run1(3'b010, 4'd0, 4'd1, 4'd10, 8'hEF);
      run1(3'b111, 4'd5, 4'd0, 4'd11, 8'h40);
      chk("mem4_sub_wrap", 32'(mem[4]), 32'h00F0);

      // Back-to-back with read-after-write on mem[3]
      issue(3'b000, 4'd1, 4'd2, 4'd3, 8'h50, 1'b1, a1);
      issue(3'b000, 4'd3, 4'd0, 4'd12, 8'h60, 1'b1, a2);
      chk("b2b_gap", 32'(a2 - a1), 32'd6);
      wait_idle();

      // Backpressure: new command offered while in RD2
      issue(3'b000, 4'd0, 4'd2, 4'd13, 8'h40, 1'b1, a1);
      cmd_opcode = 3'b001; cmd_src1 = 4'd2; cmd_src2 = 4'd0; cmd_dst = 4'd14;
      @(posedge clk); #1;
      chk("bp_ready", 32'(cmd_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_rd2_addr", 32'(mem_addr), 32'd2);
      @(posedge clk); #1;
      chk("bp_lat_addr", 32'(mem_addr), 32'd0);
      issue(3'b001, 4'd2, 4'd0, 4'd14, 8'h20, 1'b1, a2);
      chk("bp_gap", 32'(a2 - a1), 32'd6);
      wait_idle();

      // Reset during EXEC aborts the command without a write or done
      issue(3'b000, 4'd0, 4'd1, 4'd15, 8'h30, 1'b0, a1);
      cmd_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_ready", 32'(cmd_ready), 32'd1);
      chk("mr_done", 32'(done), 32'd0);
      chk("mr_done_result", 32'(done_result), 32'd0);
      chk("mr_alu_op1", 32'(alu_op1), 32'd0);
      repeat (10) @(posedge clk);
      #1;
      chk("mr_mem15", 32'(mem[15]), 32'h1234);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
